periph_bus_timeout_guard: RTL
=============================

Name: periph_bus_timeout_guard

Overview:
- Sits on the cluster peripheral-bus path, directly downstream of the core data demux's peripheral master port and upstream of the peripheral interconnect.
- Normally a transparent pass-through for one outstanding transaction.
- Watches grant and response latency; on timeout it fabricates an error response (r_opc=1) so the core never hangs.
- Reports timeouts and spurious responses as status pulses.

Parameters:
AddrWidth, 32, address width
DataWidth, 32, data width; BeWidth = DataWidth/8
IdWidth, 5, transaction id width
TimeoutCycles, 256, wait cycles before timeout; must be >=2
ErrData, 32'hBADACCE5, r_rdata returned on fabricated error response

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
enable_i  in  1  0 = pure pass-through, timeouts disabled
slv_req_i/slv_add_i/slv_wen_i/slv_wdata_i/slv_be_i/slv_id_i  in  1/AddrWidth/1/DataWidth/BeWidth/IdWidth  request from demux
slv_gnt_o  out  1  grant to demux
slv_r_valid_o/slv_r_opc_o/slv_r_rdata_o/slv_r_id_o  out  1/1/DataWidth/IdWidth  response to demux
mst_req_o/mst_add_o/mst_wen_o/mst_wdata_o/mst_be_o/mst_id_o  out  as slv  request to interconnect
mst_gnt_i  in  1  grant from interconnect
mst_r_valid_i/mst_r_opc_i/mst_r_rdata_i/mst_r_id_i  in  as slv  response from interconnect
timeout_o  out  1  one-cycle pulse per timeout event
timeout_addr_o  out  AddrWidth  address of last timed-out transaction (registered)
spurious_o  out  1  one-cycle pulse: mst_r_valid_i with nothing outstanding

Behaviour:
- Reset: state IDLE, counter 0, timeout_addr_o 0, timeout_o 0, spurious_o 0, latched addr/id 0. Combinational outputs follow IDLE rules.
- Request fields add/wen/wdata/be/id always pass through combinationally.
- Counter width = $clog2(TimeoutCycles+1). Cleared on every state change. Increments each cycle in WAIT_GNT, WAIT_RSP and ORPHAN.
- Timeout condition: counter == TimeoutCycles-1 and the awaited event is absent that cycle. If the event and the terminal count coincide, the event wins.
- IDLE:
  - mst_req_o = slv_req_i; slv_gnt_o = mst_gnt_i.
  - req & gnt -> WAIT_RSP; latch add/id.
  - req & !gnt & enable_i -> WAIT_GNT; latch add/id.
  - slv_r_valid_o = 0. mst_r_valid_i here -> spurious_o pulse next cycle; response dropped.
- WAIT_GNT:
  - Pass-through as in IDLE.
  - gnt -> WAIT_RSP.
  - slv_req_i dropped (protocol violation) -> IDLE, no error.
  - Timeout -> force mst_req_o=0 and slv_gnt_o=1 that cycle (fake grant); go ERR_RSP; timeout_o pulse next cycle; timeout_addr_o <= latched addr.
- WAIT_RSP:
  - mst_req_o=0, slv_gnt_o=0; new requests stall.
  - mst_r_valid_i -> forward r_valid/opc/rdata/r_id combinationally the same cycle; go IDLE.
  - Timeout -> ORPHAN, timeout_o pulse, timeout_addr_o updated, error response issued the same cycle: slv_r_valid_o=1, r_opc=1, r_rdata=ErrData, r_id=latched id.
- ERR_RSP (one cycle):
  - slv_r_valid_o=1, slv_r_opc_o=1, slv_r_rdata_o=ErrData, slv_r_id_o=latched id.
  - mst_req_o=0; -> IDLE.
- ORPHAN:
  - mst_req_o=0, slv_gnt_o=0, slv_r_valid_o=0.
  - Late mst_r_valid_i is swallowed -> IDLE.
  - Second timeout -> IDLE (response declared lost; no extra pulse).
- enable_i=0: FSM forced to IDLE next cycle (no error generated); pure pass-through. Spurious detection is still active.
- Latency: zero added cycles in the normal path; fabricated error arrives 1 cycle after the fake grant.
- One outstanding transaction only; the upstream demux guarantees this.

Decomposition:
- Shared package (cluster peripheral package): state enum, default ErrData constant, struct typedefs for peripheral request/response bundles.
- One natural sub-module: timeout_counter (clear, enable, terminal-count compare). Everything else is inline FSM.

Test Plan:
- Normal read: req at t0, gnt at t0, r_valid at t3 with rdata=0x1234, r_opc=0 -> forwarded same cycle; timeout_o never set; back to IDLE at t4.
- Grant timeout (TimeoutCycles=4): req held, gnt never -> cycle 4 slv_gnt_o=1 with mst_req_o=0; next cycle r_valid=1, r_opc=1, rdata=0xBADACCE5; timeout_o pulse; timeout_addr_o = request address.
- Response timeout (TimeoutCycles=4): gnt at t0, no r_valid -> t4 error response with latched id and timeout_o; late r_valid at t6 swallowed, slv_r_valid_o stays 0; t7 new request passes through.
- Boundary: gnt arrives exactly on terminal-count cycle -> normal WAIT_RSP, no timeout.
- Spurious: mst_r_valid_i in IDLE -> spurious_o pulse, slv_r_valid_o=0.
- Async reset asserted in WAIT_RSP -> all registered outputs 0 immediately; after release, first request passes through unaffected.

Source files
------------

// File: rtl/periph_bus_timeout_guard_pkg.sv
// Shared cluster peripheral-bus definitions: guard FSM states, default error
// payload and request/response bundle types at the default bus widths.
package periph_bus_timeout_guard_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_GNT,
        ST_WAIT_RSP,
        ST_ERR_RSP,
        ST_ORPHAN
    } guard_state_e;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hBADACCE5;

    localparam int unsigned PERIPH_ADDR_W = 32;
    localparam int unsigned PERIPH_DATA_W = 32;
    localparam int unsigned PERIPH_BE_W   = PERIPH_DATA_W / 8;
    localparam int unsigned PERIPH_ID_W   = 5;

    typedef struct packed {
        logic                     req;
        logic [PERIPH_ADDR_W-1:0] add;
        logic                     wen;
        logic [PERIPH_DATA_W-1:0] wdata;
        logic [PERIPH_BE_W-1:0]   be;
        logic [PERIPH_ID_W-1:0]   id;
    } periph_req_t;

    typedef struct packed {
        logic                     r_valid;
        logic                     r_opc;
        logic [PERIPH_DATA_W-1:0] r_rdata;
        logic [PERIPH_ID_W-1:0]   r_id;
    } periph_rsp_t;

    // Enough bits to hold the terminal count itself.
    function automatic int unsigned cnt_width(input int unsigned tc);
        return $clog2(tc + 1);
    endfunction

endpackage

// File: rtl/periph_bus_timeout_guard_timeout_counter.sv
// Wait-cycle counter for the timeout guard: synchronous clear, count enable
// and terminal-count flag at TimeoutCycles-1.
module periph_bus_timeout_guard_timeout_counter
    import periph_bus_timeout_guard_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 256
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int unsigned CntW = cnt_width(TimeoutCycles);

    if (TimeoutCycles < 2) begin : g_bad_timeout
        $error("TimeoutCycles must be at least 2");
    end

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == CntW'(TimeoutCycles - 1));

endmodule

// File: rtl/periph_bus_timeout_guard.sv
// Peripheral-bus timeout guard: transparent for one outstanding transaction,
// fabricates an error response when grant or response never arrives.
module periph_bus_timeout_guard
    import periph_bus_timeout_guard_pkg::*;
#(
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned IdWidth       = 5,
    parameter int unsigned TimeoutCycles = 256,
    parameter logic [DataWidth-1:0] ErrData = DataWidth'(ERR_DATA_DEFAULT),
    localparam int unsigned BeWidth      = DataWidth / 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 enable_i,

    input  logic                 slv_req_i,
    input  logic [AddrWidth-1:0] slv_add_i,
    input  logic                 slv_wen_i,
    input  logic [DataWidth-1:0] slv_wdata_i,
    input  logic [BeWidth-1:0]   slv_be_i,
    input  logic [IdWidth-1:0]   slv_id_i,
    output logic                 slv_gnt_o,
    output logic                 slv_r_valid_o,
    output logic                 slv_r_opc_o,
    output logic [DataWidth-1:0] slv_r_rdata_o,
    output logic [IdWidth-1:0]   slv_r_id_o,

    output logic                 mst_req_o,
    output logic [AddrWidth-1:0] mst_add_o,
    output logic                 mst_wen_o,
    output logic [DataWidth-1:0] mst_wdata_o,
    output logic [BeWidth-1:0]   mst_be_o,
    output logic [IdWidth-1:0]   mst_id_o,
    input  logic                 mst_gnt_i,
    input  logic                 mst_r_valid_i,
    input  logic                 mst_r_opc_i,
    input  logic [DataWidth-1:0] mst_r_rdata_i,
    input  logic [IdWidth-1:0]   mst_r_id_i,

    output logic                 timeout_o,
    output logic [AddrWidth-1:0] timeout_addr_o,
    output logic                 spurious_o
);

    guard_state_e         state_q, state_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [IdWidth-1:0]   id_q, id_d;
    logic [AddrWidth-1:0] timeout_addr_q, timeout_addr_d;
    logic                 timeout_q, spurious_q, spurious_d;
    logic                 dis_outst_q, dis_outst_d;
    logic                 timeout_evt;
    logic                 cnt_clr, cnt_en, cnt_tc;
    logic                 rsp_expected;

    assign mst_add_o   = slv_add_i;
    assign mst_wen_o   = slv_wen_i;
    assign mst_wdata_o = slv_wdata_i;
    assign mst_be_o    = slv_be_i;
    assign mst_id_o    = slv_id_i;

    assign cnt_clr = (state_d != state_q);
    assign cnt_en  = (state_q == ST_WAIT_GNT) || (state_q == ST_WAIT_RSP) ||
                     (state_q == ST_ORPHAN);

    periph_bus_timeout_guard_timeout_counter #(
        .TimeoutCycles (TimeoutCycles)
    ) i_timeout_counter (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .tc_o   (cnt_tc)
    );

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        id_d          = id_q;
        timeout_evt   = 1'b0;
        mst_req_o     = slv_req_i;
        slv_gnt_o     = mst_gnt_i;
        slv_r_valid_o = 1'b0;
        slv_r_opc_o   = mst_r_opc_i;
        slv_r_rdata_o = mst_r_rdata_i;
        slv_r_id_o    = mst_r_id_i;

        if (!enable_i) begin
            // Disabled: bus fully transparent, responses forwarded untouched.
            state_d       = ST_IDLE;
            slv_r_valid_o = mst_r_valid_i;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (slv_req_i) begin
                        addr_d  = slv_add_i;
                        id_d    = slv_id_i;
                        state_d = mst_gnt_i ? ST_WAIT_RSP : ST_WAIT_GNT;
                    end
                end
                ST_WAIT_GNT: begin
                    if (!slv_req_i) begin
                        state_d = ST_IDLE;
                    end else if (mst_gnt_i) begin
                        state_d = ST_WAIT_RSP;
                    end else if (cnt_tc) begin
                        mst_req_o   = 1'b0;
                        slv_gnt_o   = 1'b1;
                        timeout_evt = 1'b1;
                        state_d     = ST_ERR_RSP;
                    end
                end
                ST_WAIT_RSP: begin
                    mst_req_o = 1'b0;
                    slv_gnt_o = 1'b0;
                    if (mst_r_valid_i) begin
                        slv_r_valid_o = 1'b1;
                        state_d       = ST_IDLE;
                    end else if (cnt_tc) begin
                        slv_r_valid_o = 1'b1;
                        slv_r_opc_o   = 1'b1;
                        slv_r_rdata_o = ErrData;
                        slv_r_id_o    = id_q;
                        timeout_evt   = 1'b1;
                        state_d       = ST_ORPHAN;
                    end
                end
                ST_ERR_RSP: begin
                    mst_req_o     = 1'b0;
                    slv_gnt_o     = 1'b0;
                    slv_r_valid_o = 1'b1;
                    slv_r_opc_o   = 1'b1;
                    slv_r_rdata_o = ErrData;
                    slv_r_id_o    = id_q;
                    state_d       = ST_IDLE;
                end
                ST_ORPHAN: begin
                    mst_req_o = 1'b0;
                    slv_gnt_o = 1'b0;
                    if (mst_r_valid_i || cnt_tc) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // In disabled mode the FSM sits in IDLE, so a one-bit tracker stands in
    // for it to tell a legitimate response from a spurious one.
    always_comb begin
        dis_outst_d = 1'b0;
        if (!enable_i) begin
            dis_outst_d = (slv_req_i && mst_gnt_i) ||
                          ((dis_outst_q || (state_q == ST_WAIT_RSP) ||
                            (state_q == ST_ORPHAN)) && !mst_r_valid_i);
        end
    end

    assign rsp_expected   = (state_q == ST_WAIT_RSP) || (state_q == ST_ORPHAN) ||
                            dis_outst_q;
    assign spurious_d     = mst_r_valid_i && !rsp_expected;
    assign timeout_addr_d = timeout_evt ? addr_q : timeout_addr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= ST_IDLE;
            addr_q         <= '0;
            id_q           <= '0;
            timeout_addr_q <= '0;
            timeout_q      <= 1'b0;
            spurious_q     <= 1'b0;
            dis_outst_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            id_q           <= id_d;
            timeout_addr_q <= timeout_addr_d;
            timeout_q      <= timeout_evt;
            spurious_q     <= spurious_d;
            dis_outst_q    <= dis_outst_d;
        end
    end

    assign timeout_o      = timeout_q;
    assign timeout_addr_o = timeout_addr_q;
    assign spurious_o     = spurious_q;

endmodule
